// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port memory between instruction fetch and data
// access. Holds at most one transaction in flight. Data has priority, but fetch is
// granted after at most DATA_BURST_MAX consecutive data grants while it is waiting.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WD        = 32,
    parameter int unsigned DATA_WD        = 32,
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               inst_req,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic [DATA_WD-1:0] inst_rdata,
    output logic               inst_data_ok,

    input  logic               data_req,
    input  logic [3:0]         data_wen,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic [DATA_WD-1:0] data_wdata,
    output logic [DATA_WD-1:0] data_rdata,
    output logic               data_data_ok,

    output logic               mem_req,
    output logic [3:0]         mem_wen,
    output logic [ADDR_WD-1:0] mem_addr,
    output logic [DATA_WD-1:0] mem_wdata,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [DATA_WD-1:0] mem_rdata,

    output logic               stallreq_if,
    output logic               stallreq_ex
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;
    typedef enum logic {OwnInst, OwnData} owner_e;

    localparam logic [3:0] BurstMax = 4'(DATA_BURST_MAX);

    state_e     state_q;
    owner_e     owner_q;
    logic [3:0] burst_q;

    logic grant_data;
    logic grant_inst;
    logic resp_fire;

    // Arbitration: data wins unless fetch has waited through a full data burst.
    assign grant_data = data_req && (!inst_req || (burst_q < BurstMax));
    assign grant_inst = !grant_data && inst_req;

    // Memory response that completes the current transaction this cycle.
    assign resp_fire = ((state_q == StAddr) && mem_addr_ok && mem_data_ok) ||
                       ((state_q == StData) && mem_data_ok);

    // Stall the pipeline stage until its own completion pulse.
    assign stallreq_if = inst_req & ~inst_data_ok;
    assign stallreq_ex = data_req & ~data_data_ok;

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnInst;
            burst_q      <= '0;
            mem_req      <= 1'b0;
            mem_wen      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_data) begin
                        owner_q   <= OwnData;
                        mem_req   <= 1'b1;
                        mem_wen   <= data_wen;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
                        state_q   <= StAddr;
                        // Count only grants that made a waiting fetch wait longer.
                        if (inst_req) begin
                            burst_q <= (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
                        end else begin
                            burst_q <= '0;
                        end
                    end else if (grant_inst) begin
                        owner_q   <= OwnInst;
                        mem_req   <= 1'b1;
                        mem_wen   <= '0;
                        mem_addr  <= inst_addr;
                        mem_wdata <= '0;
                        state_q   <= StAddr;
                        burst_q   <= '0;
                    end
                end
                StAddr: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state_q <= mem_data_ok ? StResp : StData;
                    end
                end
                StData: begin
                    if (mem_data_ok) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    // No arbitration here: requester gets a cycle to drop or replace req.
                    inst_data_ok <= 1'b0;
                    data_data_ok <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (resp_fire) begin
                if (owner_q == OwnData) begin
                    data_rdata   <= mem_rdata;
                    data_data_ok <= 1'b1;
                end else begin
                    inst_rdata   <= mem_rdata;
                    inst_data_ok <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration and memory contents.
module tb_sram_port_arbiter;

    localparam int unsigned BurstMax = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        stallreq_if;
    logic        stallreq_ex;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WD       (32),
        .DATA_WD       (32),
        .DATA_BURST_MAX(BurstMax)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_data_ok(inst_data_ok),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_data_ok(data_data_ok),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .stallreq_if (stallreq_if),
        .stallreq_ex (stallreq_ex)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wen    = '0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_A5A5);
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [3:0] wen,
                             input logic [31:0] wd);
        logic [31:0] v;
        v = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        mem_model[a] = v;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        inst_req = 1'b1;
        data_req = 1'b1;
        step();
        step();
        n_cmp++;
        if ({mem_req, mem_wen, mem_addr, mem_wdata, inst_rdata, data_rdata,
             inst_data_ok, data_data_ok} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {mem_req, mem_wen, mem_addr,
                     mem_wdata, inst_rdata, data_rdata, inst_data_ok, data_data_ok});
        end
        clear_inputs();
        #1;
        n_cmp++;
        if ({stallreq_if, stallreq_ex} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_stallreq: got %b want 00", {stallreq_if, stallreq_ex});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        n_cmp++;
        if ({stallreq_if, mem_req} !== 2'b10) begin
            n_err++;
            $display("FAIL fetch_c0: got stall/req %b want 10", {stallreq_if, mem_req});
        end
        step();
        n_cmp++;
        if ({mem_req, mem_wen, mem_addr, mem_wdata, stallreq_if} !==
            {1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_c1: got %h want %h",
                     {mem_req, mem_wen, mem_addr, mem_wdata, stallreq_if},
                     {1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b1});
        end
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h3C01_0001;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        n_cmp++;
        if ({inst_data_ok, inst_rdata, data_data_ok, mem_req, stallreq_if} !==
            {1'b1, 32'h3C01_0001, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_c2: got %h want %h",
                     {inst_data_ok, inst_rdata, data_data_ok, mem_req, stallreq_if},
                     {1'b1, 32'h3C01_0001, 1'b0, 1'b0, 1'b0});
        end
        inst_req = 1'b0;
        step();
        n_cmp++;
        if (inst_data_ok !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_c3_pulse: got %b want 0", inst_data_ok);
        end
    endtask

    task automatic test_collision();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_2222;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0004;
        data_req    = 1'b1;
        data_wen    = 4'hF;
        data_addr   = 32'h8000_1000;
        data_wdata  = 32'hDEAD_BEEF;
        step();
        n_cmp++;
        if ({mem_req, mem_wen, mem_addr, mem_wdata} !==
            {1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL coll_data_issue: got %h want %h",
                     {mem_req, mem_wen, mem_addr, mem_wdata},
                     {1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF});
        end
        step();
        n_cmp++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            n_err++;
            $display("FAIL coll_data_ok: got %b want 10", {data_data_ok, inst_data_ok});
        end
        data_req = 1'b0;
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL coll_c3_idle: got mem_req %b want 0", mem_req);
        end
        step();
        n_cmp++;
        if ({mem_req, mem_wen, mem_addr, mem_wdata} !==
            {1'b1, 4'h0, 32'hBFC0_0004, 32'h0}) begin
            n_err++;
            $display("FAIL coll_inst_issue: got %h want %h",
                     {mem_req, mem_wen, mem_addr, mem_wdata},
                     {1'b1, 4'h0, 32'hBFC0_0004, 32'h0});
        end
        step();
        n_cmp++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h1111_2222}) begin
            n_err++;
            $display("FAIL coll_inst_ok: got %h want %h",
                     {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'h1111_2222});
        end
        clear_inputs();
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] is_inst;
        int         grants;
        bit         prev_req;
        bit         done;
        is_inst     = '0;
        grants      = 0;
        prev_req    = mem_req;
        done        = 0;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_0042;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0100;
        data_req    = 1'b1;
        data_wen    = 4'h0;
        data_addr   = 32'h8000_0000;
        for (int c = 0; c < 80 && !done; c++) begin
            step();
            if (mem_req && !prev_req && grants < 10) begin
                is_inst[grants] = (mem_addr[31:28] == 4'hB);
                grants++;
            end
            prev_req = mem_req;
            if (inst_data_ok) begin
                if (grants >= 10) begin
                    done     = 1;
                    inst_req = 1'b0;
                    data_req = 1'b0;
                end else begin
                    inst_addr = inst_addr + 32'd4;
                end
            end
            if (data_data_ok) data_addr = data_addr + 32'd4;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL starve_timeout: got %0d grants done=%0d want 10 done=1",
                     grants, done);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (is_inst[i] !== ((i % 5) == 4)) begin
                n_err++;
                $display("FAIL starve_grant%0d: got inst=%b want inst=%b",
                         i, is_inst[i], ((i % 5) == 4));
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_wait_states();
        bit exp_req;
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'h8000_2000;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_req = ((c >= 1) && (c <= 3)) || (c == 9);
            n_cmp++;
            if (mem_req !== exp_req) begin
                n_err++;
                $display("FAIL wait_req_c%0d: got %b want %b", c, mem_req, exp_req);
            end
            if (exp_req) begin
                n_cmp++;
                if (mem_addr !== ((c == 9) ? 32'hBFC0_0200 : 32'h8000_2000)) begin
                    n_err++;
                    $display("FAIL wait_addr_c%0d: got %h", c, mem_addr);
                end
            end
            n_cmp++;
            if ({data_data_ok, inst_data_ok} !== {(c == 7), (c == 10)}) begin
                n_err++;
                $display("FAIL wait_ok_c%0d: got %b want %b", c,
                         {data_data_ok, inst_data_ok}, {(c == 7), (c == 10)});
            end
            if (c == 7) begin
                n_cmp++;
                if (data_rdata !== 32'hCAFE_F00D) begin
                    n_err++;
                    $display("FAIL wait_rdata: got %h want cafef00d", data_rdata);
                end
            end
            if (c == 10) begin
                n_cmp++;
                if (inst_rdata !== 32'h1357_2468) begin
                    n_err++;
                    $display("FAIL wait_inst_rdata: got %h want 13572468", inst_rdata);
                end
            end
            if (c == 2) begin
                inst_req  = 1'b1;
                inst_addr = 32'hBFC0_0200;
            end
            if (c == 7) data_req = 1'b0;
            if (c == 10) inst_req = 1'b0;
            mem_addr_ok = (c == 3) || (c == 9);
            mem_data_ok = (c == 6) || (c == 9);
            mem_rdata   = (c == 9) ? 32'h1357_2468 : 32'hCAFE_F00D;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'h8000_3000;
        step();
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        n_cmp++;
        if ({mem_req, data_data_ok} !== 2'b00) begin
            n_err++;
            $display("FAIL rmid_in_data: got %b want 00", {mem_req, data_data_ok});
        end
        rst = 1'b0;
        step();
        rst      = 1'b1;
        data_req = 1'b0;
        n_cmp++;
        if ({mem_req, mem_wen, mem_addr, mem_wdata, inst_rdata, data_rdata,
             inst_data_ok, data_data_ok} !== '0) begin
            n_err++;
            $display("FAIL rmid_outputs: got %h want 0", {mem_req, mem_wen, mem_addr,
                     mem_wdata, inst_rdata, data_rdata, inst_data_ok, data_data_ok});
        end
        step();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            step();
            mem_data_ok = 1'b0;
            n_cmp++;
            if ({data_data_ok, inst_data_ok, mem_req, data_rdata} !== '0) begin
                n_err++;
                $display("FAIL rmid_stray%0d: got %h want 0", c,
                         {data_data_ok, inst_data_ok, mem_req, data_rdata});
            end
        end
        clear_inputs();
    endtask

    task automatic test_idle();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hA5A5_0001;
        data_req    = 1'b1;
        data_addr   = 32'h8000_4000;
        step();
        step();
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0300;
        mem_rdata = 32'h5A5A_0002;
        step();
        step();
        step();
        inst_req = 1'b0;
        n_cmp++;
        if ({inst_data_ok, inst_rdata, data_rdata} !== {1'b1, 32'h5A5A_0002, 32'hA5A5_0001})
        begin
            n_err++;
            $display("FAIL idle_preload: got %h", {inst_data_ok, inst_rdata, data_rdata});
        end
        for (int c = 0; c < 10; c++) begin
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            step();
            n_cmp++;
            if ({mem_req, stallreq_if, stallreq_ex, inst_data_ok, data_data_ok,
                 inst_rdata, data_rdata} !==
                {5'b0, 32'h5A5A_0002, 32'hA5A5_0001}) begin
                n_err++;
                $display("FAIL idle_c%0d: got %h", c, {mem_req, stallreq_if, stallreq_ex,
                         inst_data_ok, data_data_ok, inst_rdata, data_rdata});
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        int          streak;
        bit          accepted;
        int          delay;
        bit          respond;
        bit          exp_ok_i;
        bit          exp_ok_d;
        bit          rd_check;
        logic [31:0] exp_rd;
        bit          owner_data;
        bit          prev_req;
        bit          generating;
        bit          drained;
        bit          want_data;
        bit          want_inst;
        logic [67:0] exp_fields;
        logic [31:0] a;
        streak     = 0;
        accepted   = 0;
        delay      = 0;
        exp_ok_i   = 0;
        exp_ok_d   = 0;
        rd_check   = 0;
        exp_rd     = '0;
        owner_data = 0;
        prev_req   = mem_req;
        drained    = 0;
        mem_model.delete();
        for (int cyc = 0; cyc < 4000 && !drained; cyc++) begin
            generating = (cyc < 2500);
            step();
            n_cmp++;
            if ({inst_data_ok, data_data_ok} !== {exp_ok_i, exp_ok_d}) begin
                n_err++;
                $display("FAIL rand_ok cyc%0d: got %b want %b", cyc,
                         {inst_data_ok, data_data_ok}, {exp_ok_i, exp_ok_d});
            end
            if (rd_check && (exp_ok_i || exp_ok_d)) begin
                n_cmp++;
                if ((exp_ok_d ? data_rdata : inst_rdata) !== exp_rd) begin
                    n_err++;
                    $display("FAIL rand_rdata cyc%0d: got %h want %h", cyc,
                             exp_ok_d ? data_rdata : inst_rdata, exp_rd);
                end
            end
            if (mem_req && !prev_req) begin
                want_data = data_req && (!inst_req || (streak < BurstMax));
                want_inst = !want_data && inst_req;
                exp_fields = want_data ? {data_wen, data_addr, data_wdata}
                                       : {4'h0, inst_addr, 32'h0};
                n_cmp++;
                if (!(want_data || want_inst) ||
                    ({mem_wen, mem_addr, mem_wdata} !== exp_fields)) begin
                    n_err++;
                    $display("FAIL rand_grant cyc%0d: got %h want %h (d=%0d i=%0d)", cyc,
                             {mem_wen, mem_addr, mem_wdata}, exp_fields, want_data,
                             want_inst);
                end
                if (want_data) streak = inst_req ? ((streak < 15) ? streak + 1 : 15) : 0;
                else streak = 0;
                owner_data = want_data;
                accepted   = 0;
            end
            prev_req = mem_req;
            n_cmp++;
            if ({stallreq_if, stallreq_ex} !==
                {inst_req & ~inst_data_ok, data_req & ~data_data_ok}) begin
                n_err++;
                $display("FAIL rand_stall cyc%0d: got %b", cyc, {stallreq_if, stallreq_ex});
            end
            if (inst_data_ok) inst_req = 1'b0;
            if (data_data_ok) data_req = 1'b0;
            if (generating && !inst_req && $urandom_range(0, 2) == 0) begin
                inst_req  = 1'b1;
                inst_addr = 32'h8000_0000 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (generating && !data_req && $urandom_range(0, 1) == 0) begin
                data_req   = 1'b1;
                data_addr  = 32'h8000_0000 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                data_wen   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                data_wdata = $urandom;
            end
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
            exp_ok_i    = 0;
            exp_ok_d    = 0;
            respond     = 0;
            if (mem_req && !accepted) begin
                if ($urandom_range(0, 1) == 1) begin
                    mem_addr_ok = 1'b1;
                    accepted    = 1;
                    delay       = $urandom_range(0, 3);
                    respond     = (delay == 0);
                end
            end else if (accepted) begin
                delay--;
                respond = (delay <= 0);
            end else if ($urandom_range(0, 7) == 0) begin
                mem_data_ok = 1'b1;
            end
            if (respond) begin
                accepted    = 0;
                mem_data_ok = 1'b1;
                mem_rdata   = mem_read(mem_addr);
                a           = owner_data ? data_addr : inst_addr;
                rd_check    = !owner_data || (data_wen == 4'h0);
                exp_rd      = mem_read(a);
                if (owner_data && data_wen != 4'h0) mem_write(a, data_wen, data_wdata);
                exp_ok_i    = !owner_data;
                exp_ok_d    = owner_data;
            end
            drained = !generating && !inst_req && !data_req && !mem_req && !accepted &&
                      !exp_ok_i && !exp_ok_d;
        end
        n_cmp++;
        if (!drained) begin
            n_err++;
            $display("FAIL rand_drain: got busy want idle");
        end
        clear_inputs();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_wait_states();
        test_reset_mid();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
